// File: rtl/note_player.sv
// note_player: holds one note/duration pair from song_reader, counts beats
// until the note expires, and advances a phase accumulator for the sine
// sample stage on each sample request.
//
// Ports:
//   clk                  system clock
//   reset                asynchronous, active-high reset
//   play_enable          1 = run, 0 = pause (counter, phase and state freeze)
//   note                 note number from song_reader (0 = rest)
//   duration             note length in beats
//   load_new_note        one-cycle pulse: latch note/duration
//   beat                 one-cycle beat strobe
//   generate_next_sample one-cycle sample request
//   step_size            frequency_rom step for rom_note (valid 1 cycle later)
//   rom_note             latched note, frequency_rom address
//   phase                registered phase accumulator
//   sample_valid         one-cycle pulse, phase updated for a request
//   active               1 while a non-rest note is sounding
//   note_done            one-cycle pulse when the current note expires
module note_player #(
  parameter int unsigned NOTE_W = 6,
  parameter int unsigned DUR_W  = 6,
  parameter int unsigned STEP_W = 20,
  parameter int unsigned ACC_W  = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_enable,
  input  logic [NOTE_W-1:0] note,
  input  logic [DUR_W-1:0]  duration,
  input  logic              load_new_note,
  input  logic              beat,
  input  logic              generate_next_sample,
  input  logic [STEP_W-1:0] step_size,
  output logic [NOTE_W-1:0] rom_note,
  output logic [ACC_W-1:0]  phase,
  output logic              sample_valid,
  output logic              active,
  output logic              note_done
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ROM,
    PLAY,
    REST
  } state_t;

  state_t           state;
  logic [DUR_W-1:0] count;
  logic [ACC_W-1:0] step_ext;

  assign step_ext = {{(ACC_W-STEP_W){1'b0}}, step_size};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rom_note     <= '0;
      count        <= '0;
      phase        <= '0;
      sample_valid <= 1'b0;
      active       <= 1'b0;
      note_done    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      note_done    <= 1'b0;
      // A load pre-empts everything else this cycle, including a final
      // beat of the previous note, so the old note never reports done.
      if (load_new_note) begin
        rom_note <= note;
        count    <= duration;
        phase    <= '0;
        active   <= 1'b0;
        if (duration == '0) begin
          state     <= IDLE;
          note_done <= 1'b1;
        end else begin
          state <= WAIT_ROM;
        end
      end else begin
        case (state)
          // One cycle for frequency_rom to present step_size for rom_note.
          WAIT_ROM: begin
            if (rom_note != '0) begin
              state  <= PLAY;
              active <= 1'b1;
            end else begin
              state  <= REST;
              active <= 1'b0;
            end
          end
          PLAY, REST: begin
            if (play_enable) begin
              if (beat) begin
                count <= count - DUR_W'(1);
                if (count == DUR_W'(1)) begin
                  state     <= IDLE;
                  active    <= 1'b0;
                  note_done <= 1'b1;
                end
              end
              if (generate_next_sample) begin
                sample_valid <= 1'b1;
                phase        <= (state == PLAY) ? phase + step_ext : '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;

  logic        clk;
  logic        reset;
  logic        play_enable;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        load_new_note;
  logic        beat;
  logic        generate_next_sample;
  logic [19:0] step_size;
  logic [5:0]  rom_note;
  logic [21:0] phase;
  logic        sample_valid;
  logic        active;
  logic        note_done;

  note_player #(
    .NOTE_W(6),
    .DUR_W (6),
    .STEP_W(20),
    .ACC_W (22)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .play_enable         (play_enable),
    .note                (note),
    .duration            (duration),
    .load_new_note       (load_new_note),
    .beat                (beat),
    .generate_next_sample(generate_next_sample),
    .step_size           (step_size),
    .rom_note            (rom_note),
    .phase               (phase),
    .sample_valid        (sample_valid),
    .active              (active),
    .note_done           (note_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [5:0]  nt;
    logic [5:0]  du;
    logic        bt;
    logic        gn;
    logic        pe;
    logic [19:0] st;
    logic        sv;
    logic [21:0] ph;
    logic        act;
    logic        dn;
    logic [5:0]  rom;
  } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [21:0] sb[$];

  function automatic vec_t mk(input logic ld, input logic [5:0] nt, input logic [5:0] du,
                              input logic bt, input logic gn, input logic pe,
                              input logic [19:0] st, input logic sv, input logic [21:0] ph,
                              input logic act, input logic dn, input logic [5:0] rom);
    vec_t v;
    v.ld = ld; v.nt = nt; v.du = du; v.bt = bt; v.gn = gn; v.pe = pe; v.st = st;
    v.sv = sv; v.ph = ph; v.act = act; v.dn = dn; v.rom = rom;
    return v;
  endfunction

  task automatic chk(input string nm, input string fld, input logic [31:0] act_v,
                     input logic [31:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act_v, exp_v);
    end
  endtask

  // Drive one cycle of stimulus, then check outputs just after the edge.
  task automatic apply(input vec_t v, input string nm);
    logic [21:0] e;
    load_new_note        = v.ld;
    note                 = v.nt;
    duration             = v.du;
    beat                 = v.bt;
    generate_next_sample = v.gn;
    play_enable          = v.pe;
    step_size            = v.st;
    if (v.sv) sb.push_back(v.ph);
    @(posedge clk);
    #1;
    chk(nm, "sample_valid", {31'd0, sample_valid}, {31'd0, v.sv});
    if (sample_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL %s.sb_empty: sample_valid with no expected sample", nm);
      end else begin
        e = sb.pop_front();
        chk(nm, "sb_phase", {10'd0, phase}, {10'd0, e});
      end
    end else if (v.sv && sb.size() > 0) begin
      void'(sb.pop_back());
    end
    chk(nm, "phase", {10'd0, phase}, {10'd0, v.ph});
    chk(nm, "active", {31'd0, active}, {31'd0, v.act});
    chk(nm, "note_done", {31'd0, note_done}, {31'd0, v.dn});
    chk(nm, "rom_note", {26'd0, rom_note}, {26'd0, v.rom});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [19:0] S = 20'h00100;

  vec_t basic[13];

  initial begin
    // Basic note: note=1, duration=8, step=0x100.
    basic[0]  = mk(1, 1, 8, 0, 0, 1, S, 0, 22'h0,   0, 0, 1);
    basic[1]  = mk(0, 0, 0, 1, 1, 1, S, 0, 22'h0,   1, 0, 1); // WAIT_ROM ignores both
    basic[2]  = mk(0, 0, 0, 1, 1, 1, S, 1, 22'h100, 1, 0, 1); // beat 1
    basic[3]  = mk(0, 0, 0, 0, 1, 1, S, 1, 22'h200, 1, 0, 1);
    basic[4]  = mk(0, 0, 0, 1, 1, 1, S, 1, 22'h300, 1, 0, 1); // beat 2
    basic[5]  = mk(0, 0, 0, 1, 0, 1, S, 0, 22'h300, 1, 0, 1); // beat 3
    basic[6]  = mk(0, 0, 0, 1, 0, 1, S, 0, 22'h300, 1, 0, 1);
    basic[7]  = mk(0, 0, 0, 1, 0, 1, S, 0, 22'h300, 1, 0, 1);
    basic[8]  = mk(0, 0, 0, 1, 0, 1, S, 0, 22'h300, 1, 0, 1);
    basic[9]  = mk(0, 0, 0, 1, 0, 1, S, 0, 22'h300, 1, 0, 1); // beat 7
    basic[10] = mk(0, 0, 0, 0, 0, 1, S, 0, 22'h300, 1, 0, 1);
    basic[11] = mk(0, 0, 0, 1, 0, 1, S, 0, 22'h300, 0, 1, 1); // beat 8 -> done
    basic[12] = mk(0, 0, 0, 0, 0, 1, S, 0, 22'h300, 0, 0, 1);

    reset = 1'b1; play_enable = 1'b0; note = '0; duration = '0; load_new_note = 1'b0;
    beat = 1'b0; generate_next_sample = 1'b0; step_size = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset", "phase", {10'd0, phase}, 32'd0);
    chk("reset", "sample_valid", {31'd0, sample_valid}, 32'd0);
    chk("reset", "active", {31'd0, active}, 32'd0);
    chk("reset", "note_done", {31'd0, note_done}, 32'd0);
    chk("reset", "rom_note", {26'd0, rom_note}, 32'd0);

    apply(mk(0, 0, 0, 1, 1, 1, S, 0, 22'h0, 0, 0, 0), "idle_bg");
    apply(mk(0, 0, 0, 0, 1, 1, S, 0, 22'h0, 0, 0, 0), "idle_g");

    for (int i = 0; i < 13; i++) apply(basic[i], $sformatf("basic%0d", i));

    // Wrap: accumulate 4 x 0xFFFC0 = 0x3FFF00, then +0x200 wraps to 0x100.
    apply(mk(1, 2, 20, 0, 0, 1, 20'hFFFC0, 0, 22'h0, 0, 0, 2), "wrap_ld");
    apply(mk(0, 0, 0, 0, 0, 1, 20'hFFFC0, 0, 22'h0, 1, 0, 2), "wrap_rom");
    apply(mk(0, 0, 0, 0, 1, 1, 20'hFFFC0, 1, 22'h0FFFC0, 1, 0, 2), "wrap_a1");
    apply(mk(0, 0, 0, 0, 1, 1, 20'hFFFC0, 1, 22'h1FFF80, 1, 0, 2), "wrap_a2");
    apply(mk(0, 0, 0, 0, 1, 1, 20'hFFFC0, 1, 22'h2FFF40, 1, 0, 2), "wrap_a3");
    apply(mk(0, 0, 0, 0, 1, 1, 20'hFFFC0, 1, 22'h3FFF00, 1, 0, 2), "wrap_a4");
    apply(mk(0, 0, 0, 0, 1, 1, 20'h00200, 1, 22'h000100, 1, 0, 2), "wrap");

    // Rest loaded over a playing note: abort without note_done.
    apply(mk(1, 0, 2, 0, 0, 1, S, 0, 22'h0, 0, 0, 0), "rest_ld");
    apply(mk(0, 0, 0, 0, 0, 1, S, 0, 22'h0, 0, 0, 0), "rest_rom");
    apply(mk(0, 0, 0, 1, 1, 1, S, 1, 22'h0, 0, 0, 0), "rest_bg");
    apply(mk(0, 0, 0, 0, 1, 1, S, 1, 22'h0, 0, 0, 0), "rest_g");
    apply(mk(0, 0, 0, 1, 0, 1, S, 0, 22'h0, 0, 1, 0), "rest_done");
    apply(mk(0, 0, 0, 0, 0, 1, S, 0, 22'h0, 0, 0, 0), "rest_after");

    // Pause: duration 4, two beats, five frozen beats+requests, two more.
    apply(mk(1, 3, 4, 0, 0, 1, S, 0, 22'h0, 0, 0, 3), "pause_ld");
    apply(mk(0, 0, 0, 0, 0, 1, S, 0, 22'h0, 1, 0, 3), "pause_rom");
    apply(mk(0, 0, 0, 1, 1, 1, S, 1, 22'h100, 1, 0, 3), "pause_b1");
    apply(mk(0, 0, 0, 1, 0, 1, S, 0, 22'h100, 1, 0, 3), "pause_b2");
    for (int i = 0; i < 5; i++)
      apply(mk(0, 0, 0, 1, 1, 0, S, 0, 22'h100, 1, 0, 3), $sformatf("paused%0d", i));
    apply(mk(0, 0, 0, 1, 0, 1, S, 0, 22'h100, 1, 0, 3), "pause_b3");
    apply(mk(0, 0, 0, 1, 0, 1, S, 0, 22'h100, 0, 1, 3), "pause_done");

    // Load coincident with the final beat: no done, new note runs 3 beats.
    apply(mk(1, 4, 2, 0, 0, 1, S, 0, 22'h0, 0, 0, 4), "coll_ld");
    apply(mk(0, 0, 0, 0, 0, 1, S, 0, 22'h0, 1, 0, 4), "coll_rom");
    apply(mk(0, 0, 0, 1, 0, 1, S, 0, 22'h0, 1, 0, 4), "coll_b1");
    apply(mk(1, 5, 3, 1, 0, 1, S, 0, 22'h0, 0, 0, 5), "coll_hit");
    apply(mk(0, 0, 0, 0, 0, 1, S, 0, 22'h0, 1, 0, 5), "coll_rom2");
    apply(mk(0, 0, 0, 1, 0, 1, S, 0, 22'h0, 1, 0, 5), "coll_n1");
    apply(mk(0, 0, 0, 1, 0, 1, S, 0, 22'h0, 1, 0, 5), "coll_n2");
    apply(mk(0, 0, 0, 1, 0, 1, S, 0, 22'h0, 0, 1, 5), "coll_done");

    // Zero duration: done on the next cycle, then idle.
    apply(mk(1, 6, 0, 0, 0, 1, S, 0, 22'h0, 0, 1, 6), "dur0");
    apply(mk(0, 0, 0, 1, 1, 1, S, 0, 22'h0, 0, 0, 6), "dur0_idle");

    // Async reset with counter at 5.
    apply(mk(1, 7, 8, 0, 0, 1, 20'h00040, 0, 22'h0, 0, 0, 7), "ar_ld");
    apply(mk(0, 0, 0, 0, 0, 1, 20'h00040, 0, 22'h0, 1, 0, 7), "ar_rom");
    apply(mk(0, 0, 0, 1, 1, 1, 20'h00040, 1, 22'h40, 1, 0, 7), "ar_b1");
    apply(mk(0, 0, 0, 1, 0, 1, 20'h00040, 0, 22'h40, 1, 0, 7), "ar_b2");
    apply(mk(0, 0, 0, 1, 0, 1, 20'h00040, 0, 22'h40, 1, 0, 7), "ar_b3");
    beat = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst", "phase", {10'd0, phase}, 32'd0);
    chk("async_rst", "active", {31'd0, active}, 32'd0);
    chk("async_rst", "rom_note", {26'd0, rom_note}, 32'd0);
    chk("async_rst", "note_done", {31'd0, note_done}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++)
      apply(mk(0, 0, 0, 1, 0, 1, S, 0, 22'h0, 0, 0, 0), $sformatf("post_rst%0d", i));
    apply(mk(1, 1, 1, 0, 0, 1, S, 0, 22'h0, 0, 0, 1), "again_ld");
    apply(mk(0, 0, 0, 0, 0, 1, S, 0, 22'h0, 1, 0, 1), "again_rom");
    apply(mk(0, 0, 0, 1, 1, 1, S, 1, 22'h100, 0, 1, 1), "again_done");
    apply(mk(0, 0, 0, 0, 0, 1, S, 0, 22'h100, 0, 0, 1), "again_idle");

    chk("scoreboard", "leftover", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
